// File: rtl/angle_quadrant_reducer.sv
// Range-reduces a signed angle in degrees to [0,359] using one +/-360 step per cycle.
// It then emits the quadrant and the reference angle (0..90) with a one-cycle strobe.
module angle_quadrant_reducer #(
    parameter int ANGLE_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [ANGLE_W-1:0] angle_in,
    output logic               in_ready,
    output logic               busy,
    output logic               out_valid,
    output logic [1:0]         quadrant,
    output logic [ANGLE_W-1:0] ref_angle
);

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        MAP
    } state_t;

    localparam logic signed [ANGLE_W:0] DEG_90  = (ANGLE_W+1)'(90);
    localparam logic signed [ANGLE_W:0] DEG_180 = (ANGLE_W+1)'(180);
    localparam logic signed [ANGLE_W:0] DEG_270 = (ANGLE_W+1)'(270);
    localparam logic signed [ANGLE_W:0] DEG_360 = (ANGLE_W+1)'(360);

    state_t                    state_q, state_d;
    logic signed [ANGLE_W:0]   w_q, w_d;
    logic                      out_valid_q, out_valid_d;
    logic [1:0]                quadrant_q, quadrant_d;
    logic [ANGLE_W-1:0]        ref_angle_q, ref_angle_d;

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        out_valid_d = 1'b0;
        quadrant_d  = quadrant_q;
        ref_angle_d = ref_angle_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_d     = {angle_in[ANGLE_W-1], angle_in};
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                // The extra working bit keeps both correction directions overflow-free.
                if (w_q[ANGLE_W]) begin
                    w_d = w_q + DEG_360;
                end else if (w_q >= DEG_360) begin
                    w_d = w_q - DEG_360;
                end else begin
                    state_d = MAP;
                end
            end
            MAP: begin
                if (w_q <= DEG_90) begin
                    quadrant_d  = 2'd0;
                    ref_angle_d = ANGLE_W'(w_q);
                end else if (w_q <= DEG_180) begin
                    quadrant_d  = 2'd1;
                    ref_angle_d = ANGLE_W'(DEG_180 - w_q);
                end else if (w_q <= DEG_270) begin
                    quadrant_d  = 2'd2;
                    ref_angle_d = ANGLE_W'(w_q - DEG_180);
                end else begin
                    quadrant_d  = 2'd3;
                    ref_angle_d = ANGLE_W'(DEG_360 - w_q);
                end
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            w_q         <= '0;
            out_valid_q <= 1'b0;
            quadrant_q  <= '0;
            ref_angle_q <= '0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            out_valid_q <= out_valid_d;
            quadrant_q  <= quadrant_d;
            ref_angle_q <= ref_angle_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == REDUCE) || (state_q == MAP);
    assign out_valid = out_valid_q;
    assign quadrant  = quadrant_q;
    assign ref_angle = ref_angle_q;

endmodule

// File: tb/tb_angle_quadrant_reducer.sv
// Scoreboard bench for angle_quadrant_reducer: each accept pushes its expected result.
// The monitor pops that entry on out_valid and checks quadrant, ref_angle and latency.
module tb_angle_quadrant_reducer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] angle_in = '0;
    logic         in_ready, busy, out_valid;
    logic [1:0]   quadrant;
    logic [W-1:0] ref_angle;

    angle_quadrant_reducer #(.ANGLE_W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .angle_in  (angle_in),
        .in_ready  (in_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .quadrant  (quadrant),
        .ref_angle (ref_angle)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          angle;
        logic [1:0]  q;
        logic [W-1:0] r;
        int unsigned lat;
        int unsigned acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic last_accept_ov = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: true modulo, correction count from the floor/ceil formula, quadrant table.
    function automatic exp_t model(input int a);
        exp_t e;
        int   n, m;
        n = (a >= 0) ? a / 360 : (-a + 359) / 360;
        m = a % 360;
        if (m < 0) m = m + 360;
        e.angle = a;
        e.lat   = n + 2;
        e.acc   = 0;
        if (m <= 90)       begin e.q = 2'd0; e.r = W'(m);       end
        else if (m <= 180) begin e.q = 2'd1; e.r = W'(180 - m); end
        else if (m <= 270) begin e.q = 2'd2; e.r = W'(m - 180); end
        else               begin e.q = 2'd3; e.r = W'(360 - m); end
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (sb.size() == 0) begin
                check_eq("spurious out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq($sformatf("quadrant(%0d)", e.angle), 32'(quadrant), 32'(e.q));
                check_eq($sformatf("ref_angle(%0d)", e.angle), 32'(ref_angle), 32'(e.r));
                check_eq($sformatf("latency(%0d)", e.angle), cyc - e.acc, e.lat);
            end
        end
    end

    // Called just after a rising edge; accepts on the first edge where in_ready is high.
    task automatic send(input int a);
        exp_t        e;
        int unsigned t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check_eq($sformatf("in_ready timeout(%0d)", a), 32'(in_ready), 32'd1);
        end else begin
            in_valid       = 1'b1;
            angle_in       = W'(a);
            last_accept_ov = out_valid;
            e              = model(a);
            e.acc          = cyc + 1;
            sb.push_back(e);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int unsigned t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check_eq("drain timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int sweep[] = '{0, 45, 90, 135, 180, 225, 270, 315, 359};
    int wraps[] = '{405, 720, -30, -360, -32768, 32767};

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b1;
        angle_in = W'(123);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset out_valid", 32'(out_valid), 32'd0);
        check_eq("reset quadrant", 32'(quadrant), 32'd0);
        check_eq("reset ref_angle", 32'(ref_angle), 32'd0);
        check_eq("reset in_ready", 32'(in_ready), 32'd1);
        check_eq("reset busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;

        foreach (sweep[i]) send(sweep[i]);
        wait_drain();

        foreach (wraps[i]) send(wraps[i]);
        wait_drain();

        // Request pulse while busy must be dropped.
        send(1000);
        @(negedge clk);
        check_eq("busy during reduce", 32'(busy), 32'd1);
        check_eq("in_ready during reduce", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        angle_in = W'(45);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_drain();
        repeat (6) @(posedge clk);
        #1;

        send(30);
        send(150);
        check_eq("b2b accept in strobe cycle", 32'(last_accept_ov), 32'd1);
        wait_drain();

        // Reset during REDUCE abandons the angle.
        send(3600);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check_eq("post-reset in_ready", 32'(in_ready), 32'd1);
        check_eq("post-reset busy", 32'(busy), 32'd0);
        check_eq("post-reset out_valid", 32'(out_valid), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        send(60);
        wait_drain();
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
